// File: rtl/bus_target_resp.sv
// Purpose: external-bus target; one transfer at a time, programmable wait states,
//          byte-lane decode onto a 1-cycle-latency 32-bit SRAM.
// Latency/backpressure: rdy at 2+WS (write), 3+WS (read), 1 (error); the master holds en until rdy.
module bus_target_resp #(
   parameter int ADDR_W      = 32,
   parameter int WAIT_STATES = 2
) (
   input  logic              clk_i,
   input  logic              a_reset_h_i,
   input  logic              bus_en_i,
   input  logic              bus_we_i,
   input  logic [1:0]        bus_size_i,
   input  logic [ADDR_W-1:0] bus_addr_i,
   input  logic [31:0]       bus_wdata_i,
   output logic              bus_rdy_o,
   output logic              bus_err_o,
   output logic [31:0]       bus_rdata_o,
   output logic              mem_cs_o,
   output logic              mem_we_o,
   output logic [3:0]        mem_be_o,
   output logic [ADDR_W-3:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic [31:0]       mem_rdata_i
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WAIT = 3'd1,
      S_MEM  = 3'd2,
      S_CAPT = 3'd3,
      S_RESP = 3'd4
   } state_t;

   // Wait counter is loaded with WS-1 so WAIT lasts exactly WS cycles.
   localparam logic [7:0] LP_WS_M1 = (WAIT_STATES > 0) ? 8'(WAIT_STATES - 1) : 8'd0;
   localparam logic       LP_HAS_WAIT = (WAIT_STATES > 0);

   state_t              r_state;
   state_t              w_next;
   logic                r_we;
   logic [1:0]          r_size;
   logic [ADDR_W-1:0]   r_addr;
   logic [31:0]         r_wdata;
   logic                r_err;
   logic [7:0]          r_wcnt;
   logic [31:0]         r_rdata;

   logic                w_illegal;
   logic                w_cs;
   logic                w_rdy;
   logic                w_err;
   logic [3:0]          w_be;
   logic [31:0]         w_lane_wdata;
   logic [31:0]         w_shift;
   logic [31:0]         w_capt;

   // Request legality decoded straight from the bus so an error can answer in one cycle.
   always_comb begin
      w_illegal = 1'b0;
      unique case (bus_size_i)
         2'b00:   w_illegal = 1'b0;
         2'b01:   w_illegal = bus_addr_i[0];
         2'b10:   w_illegal = (bus_addr_i[1:0] != 2'b00);
         default: w_illegal = 1'b1;
      endcase
   end

   // Byte-lane enables and lane-replicated write data from the latched request.
   always_comb begin
      w_be         = 4'b0000;
      w_lane_wdata = r_wdata;
      unique case (r_size)
         2'b00: begin
            w_be         = 4'b0001 << r_addr[1:0];
            w_lane_wdata = {4{r_wdata[7:0]}};
         end
         2'b01: begin
            w_be         = r_addr[1] ? 4'b1100 : 4'b0011;
            w_lane_wdata = {2{r_wdata[15:0]}};
         end
         2'b10: begin
            w_be         = 4'b1111;
            w_lane_wdata = r_wdata;
         end
         default: begin
            w_be         = 4'b0000;
            w_lane_wdata = r_wdata;
         end
      endcase
   end

   // Right-justify SRAM read data by the byte offset and zero-extend to the transfer size.
   always_comb begin
      w_shift = mem_rdata_i >> {r_addr[1:0], 3'b000};
      w_capt  = w_shift;
      unique case (r_size)
         2'b00:   w_capt = {24'd0, w_shift[7:0]};
         2'b01:   w_capt = {16'd0, w_shift[15:0]};
         default: w_capt = w_shift;
      endcase
   end

   // State register; reset abandons any transfer in flight.
   always_ff @(posedge clk_i or posedge a_reset_h_i) begin
      if (a_reset_h_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and strobe decode; everything defaults to idle/zero.
   always_comb begin
      w_next = r_state;
      w_cs   = 1'b0;
      w_rdy  = 1'b0;
      w_err  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (bus_en_i) begin
               if (w_illegal)        w_next = S_RESP;
               else if (LP_HAS_WAIT) w_next = S_WAIT;
               else                  w_next = S_MEM;
            end
         end
         S_WAIT: begin
            if (!bus_en_i)           w_next = S_IDLE;
            else if (r_wcnt == 8'd0) w_next = S_MEM;
         end
         S_MEM: begin
            w_cs   = 1'b1;
            w_next = r_we ? S_RESP : S_CAPT;
         end
         S_CAPT: begin
            w_next = S_RESP;
         end
         S_RESP: begin
            w_rdy  = 1'b1;
            w_err  = r_err;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Request latch, wait countdown and read-data register.
   always_ff @(posedge clk_i or posedge a_reset_h_i) begin
      if (a_reset_h_i) begin
         r_we    <= 1'b0;
         r_size  <= 2'b00;
         r_addr  <= '0;
         r_wdata <= 32'd0;
         r_err   <= 1'b0;
         r_wcnt  <= 8'd0;
         r_rdata <= 32'd0;
      end else begin
         if (r_state == S_IDLE && bus_en_i) begin
            r_we    <= bus_we_i;
            r_size  <= bus_size_i;
            r_addr  <= bus_addr_i;
            r_wdata <= bus_wdata_i;
            r_err   <= w_illegal;
            r_wcnt  <= LP_WS_M1;
            // An error response reports zero read data.
            if (w_illegal) r_rdata <= 32'd0;
         end
         if (r_state == S_WAIT && r_wcnt != 8'd0) begin
            r_wcnt <= r_wcnt - 8'd1;
         end
         if (r_state == S_CAPT) begin
            r_rdata <= w_capt;
         end
      end
   end

   // SRAM side is driven only during the access cycle so it idles at zero.
   always_comb begin
      mem_cs_o    = w_cs;
      mem_we_o    = w_cs & r_we;
      mem_be_o    = w_cs ? w_be : 4'b0000;
      mem_addr_o  = w_cs ? r_addr[ADDR_W-1:2] : '0;
      mem_wdata_o = (w_cs && r_we) ? w_lane_wdata : 32'd0;
      bus_rdy_o   = w_rdy;
      bus_err_o   = w_err;
      bus_rdata_o = r_rdata;
   end

endmodule

// File: tb/tb_bus_target_resp.sv
// Directed bench for bus_target_resp with a small behavioural SRAM.
// Checks latency, lane decode, read alignment, errors, abort and mid-transfer reset.
`timescale 1ns/1ps
module tb_bus_target_resp;

   localparam int WS = 2;

   logic        clk_i = 1'b0;
   logic        a_reset_h_i = 1'b1;
   logic        bus_en_i = 1'b0;
   logic        bus_we_i = 1'b0;
   logic [1:0]  bus_size_i = 2'b00;
   logic [31:0] bus_addr_i = 32'd0;
   logic [31:0] bus_wdata_i = 32'd0;
   logic        bus_rdy_o;
   logic        bus_err_o;
   logic [31:0] bus_rdata_o;
   logic        mem_cs_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [29:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i = 32'd0;

   int n_chk = 0;
   int n_err = 0;

   logic [31:0] mem [0:15] = '{default: 32'd0};

   bus_target_resp #(.ADDR_W(32), .WAIT_STATES(WS)) dut (
      .clk_i       (clk_i),
      .a_reset_h_i (a_reset_h_i),
      .bus_en_i    (bus_en_i),
      .bus_we_i    (bus_we_i),
      .bus_size_i  (bus_size_i),
      .bus_addr_i  (bus_addr_i),
      .bus_wdata_i (bus_wdata_i),
      .bus_rdy_o   (bus_rdy_o),
      .bus_err_o   (bus_err_o),
      .bus_rdata_o (bus_rdata_o),
      .mem_cs_o    (mem_cs_o),
      .mem_we_o    (mem_we_o),
      .mem_be_o    (mem_be_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   // SRAM model: byte-enabled write, read data valid the cycle after cs.
   always @(posedge clk_i) begin
      if (mem_cs_o) begin
         if (mem_we_o) begin
            for (int b = 0; b < 4; b++)
               if (mem_be_o[b]) mem[mem_addr_o[3:0]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
         end else begin
            mem_rdata_i <= mem[mem_addr_o[3:0]];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // One transfer. Inputs set at a negedge (cycle 0); each later negedge is the next cycle.
   // With scr set, the bus fields are scrambled from cycle 1 to show they are ignored.
   task automatic xfer(input logic we, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic scr,
                       output int rdy_cyc, output logic err, output logic [31:0] rdata,
                       output int cs_cyc, output int cs_cnt, output logic [3:0] be,
                       output logic [29:0] maddr, output logic [31:0] mwdata, output logic mwe);
      rdy_cyc = -1; err = 1'b0; rdata = 32'd0;
      cs_cyc = -1; cs_cnt = 0; be = 4'd0; maddr = 30'd0; mwdata = 32'd0; mwe = 1'b0;
      @(negedge clk_i);
      bus_en_i = 1'b1; bus_we_i = we; bus_size_i = size; bus_addr_i = addr; bus_wdata_i = wdata;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(negedge clk_i);
         if (scr && cyc == 1) begin
            bus_we_i = ~we; bus_addr_i = 32'hFFFF_FFF0; bus_wdata_i = 32'h0BAD_F00D;
         end
         if (mem_cs_o) begin
            cs_cnt++; cs_cyc = cyc; be = mem_be_o; maddr = mem_addr_o;
            mwdata = mem_wdata_o; mwe = mem_we_o;
         end
         if (bus_rdy_o) begin
            rdy_cyc = cyc; err = bus_err_o; rdata = bus_rdata_o;
            break;
         end
      end
      bus_en_i = 1'b0; bus_we_i = 1'b0; bus_size_i = 2'b00; bus_addr_i = 32'd0; bus_wdata_i = 32'd0;
      @(negedge clk_i);
      chk("rdy_pulse", {31'd0, bus_rdy_o}, 32'd0);
   endtask

   int          rc, cc, cn;
   logic        er, mw;
   logic [31:0] rd, wd;
   logic [3:0]  be;
   logic [29:0] ma;

   initial begin
      // Reset state
      repeat (2) @(negedge clk_i);
      chk("rst_rdy",   {31'd0, bus_rdy_o}, 32'd0);
      chk("rst_err",   {31'd0, bus_err_o}, 32'd0);
      chk("rst_rdata", bus_rdata_o, 32'd0);
      chk("rst_cs",    {31'd0, mem_cs_o}, 32'd0);
      chk("rst_be",    {28'd0, mem_be_o}, 32'd0);
      a_reset_h_i = 1'b0;
      @(negedge clk_i);

      // Word write 0xDEADBEEF @0x10, inputs scrambled after acceptance
      xfer(1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 1'b1, rc, er, rd, cc, cn, be, ma, wd, mw);
      chk("w1_cs_cyc", cc, 3);
      chk("w1_cs_cnt", cn, 1);
      chk("w1_be",     {28'd0, be}, 32'hF);
      chk("w1_addr",   {2'd0, ma}, 32'h4);
      chk("w1_wdata",  wd, 32'hDEADBEEF);
      chk("w1_we",     {31'd0, mw}, 32'd1);
      chk("w1_rdy",    rc, 2 + WS);
      chk("w1_err",    {31'd0, er}, 32'd0);
      chk("w1_sram",   mem[4], 32'hDEADBEEF);

      // Word read back
      xfer(1'b0, 2'b10, 32'h10, 32'd0, 1'b0, rc, er, rd, cc, cn, be, ma, wd, mw);
      chk("r1_rdy",    rc, 3 + WS);
      chk("r1_we",     {31'd0, mw}, 32'd0);
      chk("r1_rdata",  rd, 32'hDEADBEEF);

      // Byte read @0x13 of 0xAABBCCDD
      xfer(1'b1, 2'b10, 32'h10, 32'hAABBCCDD, 1'b0, rc, er, rd, cc, cn, be, ma, wd, mw);
      xfer(1'b0, 2'b00, 32'h13, 32'd0, 1'b0, rc, er, rd, cc, cn, be, ma, wd, mw);
      chk("b_cs_cyc",  cc, 3);
      chk("b_be",      {28'd0, be}, 32'h8);
      chk("b_rdy",     rc, 5);
      chk("b_rdata",   rd, 32'h000000AA);

      // Half write 0x1234 @0x02 then half reads @0x02 / @0x00
      xfer(1'b1, 2'b01, 32'h02, 32'h00001234, 1'b0, rc, er, rd, cc, cn, be, ma, wd, mw);
      chk("h_be",      {28'd0, be}, 32'hC);
      chk("h_wdata",   wd, 32'h12341234);
      chk("h_addr",    {2'd0, ma}, 32'h0);
      xfer(1'b0, 2'b01, 32'h02, 32'd0, 1'b0, rc, er, rd, cc, cn, be, ma, wd, mw);
      chk("h_rd_hi",   rd, 32'h00001234);
      chk("h_rd_be",   {28'd0, be}, 32'hC);
      xfer(1'b0, 2'b01, 32'h00, 32'd0, 1'b0, rc, er, rd, cc, cn, be, ma, wd, mw);
      chk("h_rd_lo",   rd, 32'h00000000);

      // Byte write 0x5A @0x09, half read @0x08
      xfer(1'b1, 2'b00, 32'h09, 32'h0000005A, 1'b0, rc, er, rd, cc, cn, be, ma, wd, mw);
      chk("bw_be",     {28'd0, be}, 32'h2);
      chk("bw_wdata",  wd, 32'h5A5A5A5A);
      xfer(1'b0, 2'b01, 32'h08, 32'd0, 1'b0, rc, er, rd, cc, cn, be, ma, wd, mw);
      chk("bw_rdata",  rd, 32'h00005A00);

      // Illegal requests: misaligned word, reserved size, odd half
      xfer(1'b0, 2'b10, 32'h06, 32'd0, 1'b0, rc, er, rd, cc, cn, be, ma, wd, mw);
      chk("e1_rdy",    rc, 1);
      chk("e1_err",    {31'd0, er}, 32'd1);
      chk("e1_cs",     cn, 0);
      chk("e1_rdata",  rd, 32'd0);
      xfer(1'b1, 2'b11, 32'h00, 32'h1111_1111, 1'b0, rc, er, rd, cc, cn, be, ma, wd, mw);
      chk("e2_rdy",    rc, 1);
      chk("e2_err",    {31'd0, er}, 32'd1);
      chk("e2_cs",     cn, 0);
      xfer(1'b0, 2'b01, 32'h01, 32'd0, 1'b0, rc, er, rd, cc, cn, be, ma, wd, mw);
      chk("e3_err",    {31'd0, er}, 32'd1);
      chk("e3_cs",     cn, 0);

      // Abort: en dropped during WAIT
      cn = 0; rc = 0;
      @(negedge clk_i);
      bus_en_i = 1'b1; bus_we_i = 1'b1; bus_size_i = 2'b10; bus_addr_i = 32'h10; bus_wdata_i = 32'h5555_5555;
      @(negedge clk_i);
      bus_en_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (mem_cs_o) cn++;
         if (bus_rdy_o) rc++;
         @(negedge clk_i);
      end
      chk("ab_cs",     cn, 0);
      chk("ab_rdy",    rc, 0);
      chk("ab_sram",   mem[4], 32'hAABBCCDD);
      xfer(1'b0, 2'b00, 32'h13, 32'd0, 1'b0, rc, er, rd, cc, cn, be, ma, wd, mw);
      chk("ab_nx_rdy", rc, 5);
      chk("ab_nx_rd",  rd, 32'h000000AA);

      // Reset asserted in MEM of a read
      @(negedge clk_i);
      bus_en_i = 1'b1; bus_we_i = 1'b0; bus_size_i = 2'b10; bus_addr_i = 32'h10;
      repeat (3) @(negedge clk_i);
      chk("rm_cs_pre", {31'd0, mem_cs_o}, 32'd1);
      #1 a_reset_h_i = 1'b1;
      #1;
      chk("rm_cs",     {31'd0, mem_cs_o}, 32'd0);
      chk("rm_rdy",    {31'd0, bus_rdy_o}, 32'd0);
      chk("rm_rdata",  bus_rdata_o, 32'd0);
      chk("rm_be",     {28'd0, mem_be_o}, 32'd0);
      chk("rm_addr",   {2'd0, mem_addr_o}, 32'd0);
      bus_en_i = 1'b0; bus_size_i = 2'b00; bus_addr_i = 32'd0;
      repeat (2) @(negedge clk_i);
      chk("rm_hold",   {30'd0, bus_rdy_o, mem_cs_o}, 32'd0);
      a_reset_h_i = 1'b0;
      @(negedge clk_i);
      xfer(1'b0, 2'b10, 32'h10, 32'd0, 1'b0, rc, er, rd, cc, cn, be, ma, wd, mw);
      chk("rm_nx_rdy", rc, 5);
      chk("rm_nx_rd",  rd, 32'hAABBCCDD);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
